rr_arb_8b: RTL and testbench
============================

# rr_arb_8b

Round-robin arbiter that shares one downstream resource among N requesters, using rotating-priority encoding of the request vector. It sits in front of the shared resource. It accepts level requests, issues a registered one-hot grant plus an encoded grant index, holds the grant while the owner keeps requesting, and forces rotation after a bounded hold time so no requester starves.

## Interface
- N, 8, number of requesters; N >= 2, power of two.
- MAX_HOLD, 16, maximum consecutive cycles one owner keeps the grant while others wait; MAX_HOLD >= 2.
- W, $clog2(N), width of grant index (derived, not overridden).
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N  level request per requester; bit i high = requester i wants the resource.
- gnt  out  N  one-hot grant, registered; all zero when no owner.
- gnt_id  out  W  index of current owner; holds last owner when gnt_val=0.
- gnt_val  out  1  high while an owner holds the grant.
- preempt  out  1  one-cycle pulse on the cycle a grant was taken away by hold timeout.

## Operation
- State: IDLE or GRANT; pointer ptr (W bits); current owner cur (W bits); hold counter hcnt ($clog2(MAX_HOLD) bits).
- Winner search: the first set bit of the candidate vector, scanning indices ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (modulo N). "No winner" when the candidate vector is zero.
- IDLE:
  - If req != 0, select winner w with ptr as start.
  - Next state: GRANT, cur=w, hcnt=0.
  - Otherwise stay IDLE.
- GRANT, evaluated each edge:
  - Release: req[cur]==0. ptr <= cur+1 (mod N). Search req starting at cur+1.
    - Winner found: cur <= winner, hcnt=0, stay GRANT (no idle bubble).
    - No winner: go IDLE.
  - Timeout: req[cur]==1, hcnt==MAX_HOLD-1, and (req with bit cur cleared) != 0.
    - Search that masked vector from cur+1.
    - cur <= winner, ptr <= old cur+1, hcnt=0, preempt=1 for the following cycle.
  - Timeout with no other requester: keep cur, hcnt <= 0, no preempt.
  - Otherwise: hcnt <= hcnt+1.
- Outputs:
  - gnt_val = (state==GRANT).
  - gnt = one-hot(cur) when gnt_val, else 0.
  - gnt_id = cur.
- Requests from non-owners never disturb the current owner before timeout.
- A requester that drops and re-raises req in consecutive cycles loses the grant; it is then re-arbitrated with rotated priority.

## Timing
- All outputs registered; latency from req sampled high (IDLE) to gnt asserted = 1 clock.
- Release: owner drops req before edge k; the new gnt (or all-zero) is visible after edge k. Handover costs no empty cycle.
- Maximum continuous ownership with competition = MAX_HOLD cycles.
- Worst-case wait for a persistent requester = (N-1)*MAX_HOLD cycles.
- Reset (rst_n low, asynchronous, any time including mid-grant):
  - state=IDLE, ptr=0, cur=0, hcnt=0.
  - gnt=0, gnt_id=0, gnt_val=0, preempt=0, all immediately.
  - First arbitration happens on the first rising edge after rst_n deasserts.
- Wrap-around: ptr and search indices wrap N-1 -> 0.
- Simultaneous release and new requests on the same edge: release rule applies; new requests are included in the search.
- preempt is never asserted together with a release handover.

## Test plan
- Reset: hold rst_n=0 with req=8'hFF, then assert rst_n=0 mid-grant -> gnt=8'h00, gnt_id=0, gnt_val=0, preempt=0 immediately, no clock needed.
- Single request: from IDLE, req=8'b00000100 -> after next edge gnt=8'b00000100, gnt_id=2, gnt_val=1. Drop req -> after next edge gnt=0, gnt_val=0, ptr=3.
- Rotation with wrap: from ptr=0, req=8'b01000100 -> owner 2. Owner 2 drops -> owner 6 on the same edge, no bubble. Owner 6 drops with req=8'b00000101 -> ptr=7, wrap, owner 0.
- Timeout preempt (MAX_HOLD=16): req=8'hFF held -> owner 0 for exactly 16 cycles, preempt pulse, owner 1 for 16 cycles, and so on through 7 -> 0. preempt is high exactly 1 cycle per handover.
- Lone owner: req=8'b00000001 held 40 cycles -> gnt=8'b00000001 throughout, preempt never asserted.
- Idle request set: req=8'h00 for 10 cycles -> gnt_val stays 0 and gnt_id holds its last value.

Source files
------------

// File: rtl/rr_arb_8b.sv
// Round-robin arbiter: rotating-priority grant of one shared resource among N
// level requesters, with a bounded hold time that forces rotation under contention.
module rr_arb_8b #(
   parameter int N        = 8,
   parameter int MAX_HOLD = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_id,
   output logic                 gnt_val,
   output logic                 preempt
);

   localparam int W  = $clog2(N);
   localparam int HW = $clog2(MAX_HOLD);
   localparam logic [N-1:0]  ONE      = N'(1);
   localparam logic [HW-1:0] HOLD_END = HW'(MAX_HOLD - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          r_state, w_state;
   logic [W-1:0]    r_ptr, w_ptr;
   logic [W-1:0]    r_cur, w_cur;
   logic [HW-1:0]   r_hcnt, w_hcnt;
   logic            r_pre, w_pre;
   logic [N-1:0]    r_gnt;
   logic [W-1:0]    w_cur_nxt;
   logic [N-1:0]    w_masked;
   logic [W:0]      w_s_idle, w_s_rel, w_s_to;

   // Returns {found, index} of the first set bit scanning start, start+1, ... modulo N.
   function automatic logic [W:0] find_first(input logic [N-1:0] v, input logic [W-1:0] start);
      logic [W:0]   res;
      logic [W-1:0] idx;
      res = '0;
      for (int i = 0; i < N; i++) begin
         idx = start + W'(i);
         if (v[idx] && !res[W]) res = {1'b1, idx};
      end
      return res;
   endfunction

   assign w_cur_nxt = r_cur + 1'b1;
   assign w_masked  = req & ~(ONE << r_cur);
   assign w_s_idle  = find_first(req, r_ptr);
   assign w_s_rel   = find_first(req, w_cur_nxt);
   assign w_s_to    = find_first(w_masked, w_cur_nxt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_cur   <= '0;
         r_hcnt  <= '0;
         r_pre   <= 1'b0;
         r_gnt   <= '0;
      end else begin
         r_state <= w_state;
         r_ptr   <= w_ptr;
         r_cur   <= w_cur;
         r_hcnt  <= w_hcnt;
         r_pre   <= w_pre;
         r_gnt   <= (w_state == GRANT) ? (ONE << w_cur) : '0;
      end
   end

   always_comb begin
      w_state = r_state;
      w_ptr   = r_ptr;
      w_cur   = r_cur;
      w_hcnt  = r_hcnt;
      w_pre   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_s_idle[W]) begin
               w_state = GRANT;
               w_cur   = w_s_idle[W-1:0];
               w_hcnt  = '0;
            end
         end
         GRANT: begin
            if (!req[r_cur]) begin
               // Owner released: hand over on this edge so no empty cycle appears.
               w_ptr  = w_cur_nxt;
               w_hcnt = '0;
               if (w_s_rel[W]) w_cur = w_s_rel[W-1:0];
               else            w_state = IDLE;
            end else if (r_hcnt == HOLD_END) begin
               w_hcnt = '0;
               if (w_s_to[W]) begin
                  w_cur = w_s_to[W-1:0];
                  w_ptr = w_cur_nxt;
                  w_pre = 1'b1;
               end
            end else begin
               w_hcnt = r_hcnt + 1'b1;
            end
         end
         default: w_state = IDLE;
      endcase
   end

   assign gnt     = r_gnt;
   assign gnt_id  = r_cur;
   assign gnt_val = (r_state == GRANT);
   assign preempt = r_pre;

endmodule

// File: tb/tb_rr_arb_8b.sv
// Scoreboard bench for rr_arb_8b: directed and random request patterns checked
// cycle by cycle against a queue-fed reference model of the arbitration rules.
module tb_rr_arb_8b;

   localparam int N        = 8;
   localparam int MAX_HOLD = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_val;
   logic       preempt;

   rr_arb_8b #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .gnt_val (gnt_val),
      .preempt (preempt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] g;
      logic [2:0] id;
      logic       v;
      logic       p;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   // Reference model: owner and how many cycles it has already held the grant.
   bit m_busy;
   int m_own, m_ptr, m_held;
   bit m_pre;

   function automatic int search(input logic [7:0] v, input int start);
      for (int k = 0; k < N; k++)
         if (v[(start + k) % N]) return (start + k) % N;
      return -1;
   endfunction

   function automatic void model_reset();
      m_busy = 0; m_own = 0; m_ptr = 0; m_held = 0; m_pre = 0;
   endfunction

   function automatic void model_step(input logic [7:0] r);
      int         w;
      logic [7:0] others;
      m_pre = 0;
      if (!m_busy) begin
         w = search(r, m_ptr);
         if (w >= 0) begin m_busy = 1; m_own = w; m_held = 1; end
      end else if (!r[m_own]) begin
         m_ptr = (m_own + 1) % N;
         w = search(r, m_ptr);
         if (w >= 0) begin m_own = w; m_held = 1; end
         else m_busy = 0;
      end else if (m_held == MAX_HOLD) begin
         others = r;
         others[m_own] = 1'b0;
         if (others != 0) begin
            m_ptr = (m_own + 1) % N;
            m_own = search(others, m_ptr);
            m_pre = 1;
         end
         m_held = 1;
      end else begin
         m_held++;
      end
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e.g  = m_busy ? (8'd1 << m_own) : 8'd0;
      e.id = 3'(m_own);
      e.v  = m_busy;
      e.p  = m_pre;
      return e;
   endfunction

   task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, want);
      end
   endtask

   // Monitor: every falling edge compares the outputs with the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (q.size() > 0) begin
         e = q.pop_front();
         cmp("gnt",     gnt,            e.g);
         cmp("gnt_id",  {5'd0, gnt_id}, {5'd0, e.id});
         cmp("gnt_val", {7'd0, gnt_val}, {7'd0, e.v});
         cmp("preempt", {7'd0, preempt}, {7'd0, e.p});
      end
   end

   task automatic drive(input logic [7:0] v);
      @(negedge clk);
      #2;
      req = v;
      if (rst_n) model_step(v);
      else       model_reset();
      q.push_back(model_out());
   endtask

   task automatic release_rst(input logic [7:0] v);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      req   = v;
      model_step(v);
      q.push_back(model_out());
   endtask

   task automatic check_reset_outputs(input string tag);
      cmp({tag, "_gnt"},     gnt,             8'h00);
      cmp({tag, "_gnt_id"},  {5'd0, gnt_id},  8'h00);
      cmp({tag, "_gnt_val"}, {7'd0, gnt_val}, 8'h00);
      cmp({tag, "_preempt"}, {7'd0, preempt}, 8'h00);
   endtask

   task automatic async_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      model_reset();
   endtask

   initial begin
      logic [7:0] r;
      model_reset();
      rst_n = 1'b0;
      req   = 8'hFF;
      #1;
      check_reset_outputs("por");
      repeat (3) drive(8'hFF);

      // Single request, then release.
      release_rst(8'b0000_0100);
      drive(8'b0000_0100);
      drive(8'b0000_0000);
      drive(8'b0000_0000);

      // Rotation with wrap from a fresh pointer.
      async_reset();
      drive(8'h00);
      release_rst(8'b0100_0100);
      drive(8'b0100_0100);
      drive(8'b0100_0000);
      drive(8'b0100_0000);
      drive(8'b0000_0101);
      drive(8'b0000_0101);
      drive(8'b0000_0000);

      // Full contention: every requester in turn, timeout-driven rotation.
      repeat (N * MAX_HOLD + 20) drive(8'hFF);

      // Reset in the middle of a grant.
      async_reset();
      drive(8'hFF);
      release_rst(8'b0000_0001);

      // Lone owner hits the hold limit repeatedly without preemption.
      repeat (40) drive(8'b0000_0001);

      // Idle: gnt_id keeps the last owner.
      drive(8'b1000_0000);
      drive(8'b0000_0000);
      repeat (10) drive(8'h00);

      // Random traffic with sticky request vectors so holds and timeouts occur.
      r = 8'h00;
      repeat (3000) begin
         case ($urandom_range(0, 7))
            0:       r = 8'($urandom);
            1:       r = r & 8'($urandom);
            2:       r = r | (8'd1 << $urandom_range(0, 7));
            3:       r = r & ~(8'd1 << gnt_id);
            default: ;
         endcase
         drive(r);
      end

      @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: got %0d pending expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
